// File: rtl/tag_lookup_unit_if.sv
// Lookup request/response bundle between the cache set read path and the tag lookup unit.
// The requester side uses the master modport; the lookup unit uses slave.
interface tag_lookup_unit_if #(
    parameter int TAG_SIZE    = 22,
    parameter int WAYS        = 8,
    parameter int WAY_NO_SIZE = 3
);
    logic                     req_valid;
    logic                     req_ready;
    logic [TAG_SIZE-1:0]      req_tag;
    logic [WAYS*TAG_SIZE-1:0] way_tags;
    logic [WAYS-1:0]          way_valid;

    logic                     rsp_valid;
    logic                     rsp_ready;
    logic                     rsp_hit;
    logic [WAY_NO_SIZE-1:0]   rsp_way;
    logic [WAYS-1:0]          rsp_hit_vec;
    logic                     rsp_multi_hit;

    modport master (
        output req_valid, req_tag, way_tags, way_valid, rsp_ready,
        input  req_ready, rsp_valid, rsp_hit, rsp_way, rsp_hit_vec, rsp_multi_hit
    );

    modport slave (
        input  req_valid, req_tag, way_tags, way_valid, rsp_ready,
        output req_ready, rsp_valid, rsp_hit, rsp_way, rsp_hit_vec, rsp_multi_hit
    );
endinterface

// File: rtl/tag_lookup_unit.sv
// N-way parallel tag compare with a two-register valid/ready pipeline (match stage, response stage)
// and saturating hit/miss statistics counted on delivered responses.
module tag_lookup_unit #(
    parameter int TAG_SIZE    = 22,
    parameter int WAYS        = 8,
    parameter int WAY_NO_SIZE = 3,
    parameter int CNT_SIZE    = 16
) (
    input  logic                clk,
    input  logic                rst,
    tag_lookup_unit_if.slave    bus,
    input  logic                clr_counts,
    output logic [CNT_SIZE-1:0] hit_count,
    output logic [CNT_SIZE-1:0] miss_count
);

    logic [WAYS-1:0]        req_match;
    logic [WAYS-1:0]        s1_match;
    logic                   s1_valid;
    logic                   rsp_advance;
    logic                   req_accept;
    logic                   rsp_fire;
    logic                   rsp_hit_d;
    logic [WAY_NO_SIZE-1:0] rsp_way_d;
    logic                   rsp_multi_d;

    always_comb begin
        req_match = '0;
        for (int i = 0; i < WAYS; i++) begin
            req_match[i] = bus.way_valid[i] &&
                           (bus.way_tags[i*TAG_SIZE +: TAG_SIZE] == bus.req_tag);
        end
    end

    // Scan from the top down so the lowest matching way is the one left in rsp_way_d.
    always_comb begin
        rsp_way_d = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (s1_match[i]) begin
                rsp_way_d = WAY_NO_SIZE'(i);
            end
        end
    end

    assign rsp_hit_d   = |s1_match;
    // Clearing the lowest set bit leaves something only when two or more bits were set.
    assign rsp_multi_d = |(s1_match & (s1_match - WAYS'(1)));

    assign rsp_advance   = !bus.rsp_valid || bus.rsp_ready;
    assign bus.req_ready = !s1_valid || rsp_advance;
    assign req_accept    = bus.req_valid && bus.req_ready;
    assign rsp_fire      = bus.rsp_valid && bus.rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_match <= '0;
        end else if (req_accept) begin
            s1_valid <= 1'b1;
            s1_match <= req_match;
        end else if (rsp_advance) begin
            s1_valid <= 1'b0;
        end
    end

    // A bubble only clears rsp_valid; the payload keeps its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rsp_valid     <= 1'b0;
            bus.rsp_hit       <= 1'b0;
            bus.rsp_way       <= '0;
            bus.rsp_hit_vec   <= '0;
            bus.rsp_multi_hit <= 1'b0;
        end else if (rsp_advance) begin
            bus.rsp_valid <= s1_valid;
            if (s1_valid) begin
                bus.rsp_hit       <= rsp_hit_d;
                bus.rsp_way       <= rsp_way_d;
                bus.rsp_hit_vec   <= s1_match;
                bus.rsp_multi_hit <= rsp_multi_d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (clr_counts) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (rsp_fire) begin
            if (bus.rsp_hit) begin
                if (hit_count != '1) begin
                    hit_count <= hit_count + CNT_SIZE'(1);
                end
            end else begin
                if (miss_count != '1) begin
                    miss_count <= miss_count + CNT_SIZE'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_tag_lookup_unit.sv
// Directed bench for tag_lookup_unit (8 ways, 4-bit counters so saturation is reachable).
module tb_tag_lookup_unit;

    localparam int TAG_SIZE    = 22;
    localparam int WAYS        = 8;
    localparam int WAY_NO_SIZE = 3;
    localparam int CNT_SIZE    = 4;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     clr_counts = 1'b0;
    logic [CNT_SIZE-1:0]      hit_count;
    logic [CNT_SIZE-1:0]      miss_count;
    logic [WAYS*TAG_SIZE-1:0] tags;
    logic [WAYS*TAG_SIZE-1:0] base_tags;

    int checks   = 0;
    int failures = 0;

    tag_lookup_unit_if #(.TAG_SIZE(TAG_SIZE), .WAYS(WAYS), .WAY_NO_SIZE(WAY_NO_SIZE)) bus ();

    tag_lookup_unit #(
        .TAG_SIZE(TAG_SIZE), .WAYS(WAYS), .WAY_NO_SIZE(WAY_NO_SIZE), .CNT_SIZE(CNT_SIZE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .clr_counts (clr_counts),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic v, input logic [TAG_SIZE-1:0] tag,
                                 input logic [WAYS-1:0] wvalid, input logic rready);
        bus.req_valid = v;
        bus.req_tag   = tag;
        bus.way_tags  = tags;
        bus.way_valid = wvalid;
        bus.rsp_ready = rready;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    task automatic checkRsp(input string name, input logic hit, input logic [WAY_NO_SIZE-1:0] way,
                            input logic [WAYS-1:0] vec, input logic multi);
        checkOutput({name, "_valid"}, 32'(bus.rsp_valid), 32'd1);
        checkOutput({name, "_hit"}, 32'(bus.rsp_hit), 32'(hit));
        checkOutput({name, "_way"}, 32'(bus.rsp_way), 32'(way));
        checkOutput({name, "_vec"}, 32'(bus.rsp_hit_vec), 32'(vec));
        checkOutput({name, "_multi"}, 32'(bus.rsp_multi_hit), 32'(multi));
    endtask

    initial begin
        for (int i = 0; i < WAYS; i++) begin
            base_tags[i*TAG_SIZE +: TAG_SIZE] = 22'h100000 + 22'(i);
        end
        tags = base_tags;
        applyStimulus(1'b0, '0, '0, 1'b1);

        // Reset state
        tick();
        checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rst_rsp_hit", 32'(bus.rsp_hit), 32'd0);
        checkOutput("rst_rsp_way", 32'(bus.rsp_way), 32'd0);
        checkOutput("rst_hit_vec", 32'(bus.rsp_hit_vec), 32'd0);
        checkOutput("rst_multi", 32'(bus.rsp_multi_hit), 32'd0);
        checkOutput("rst_hit_count", 32'(hit_count), 32'd0);
        checkOutput("rst_miss_count", 32'(miss_count), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd1);

        // Single hit in way 5, two-edge latency, inputs changed after acceptance
        tags[5*TAG_SIZE +: TAG_SIZE] = 22'h1ABCDE;
        applyStimulus(1'b1, 22'h1ABCDE, 8'hFF, 1'b1);
        tick();
        applyStimulus(1'b0, 22'h000000, 8'h00, 1'b1);
        checkOutput("t1_latency", 32'(bus.rsp_valid), 32'd0);
        tick();
        checkRsp("t1", 1'b1, 3'd5, 8'h20, 1'b0);
        tick();
        checkOutput("t1_drain", 32'(bus.rsp_valid), 32'd0);
        checkOutput("t1_hit_count", 32'(hit_count), 32'd1);

        // Same tag in ways 2 and 6, then with way 2 masked
        tags = base_tags;
        tags[2*TAG_SIZE +: TAG_SIZE] = 22'h2AAAAA;
        tags[6*TAG_SIZE +: TAG_SIZE] = 22'h2AAAAA;
        applyStimulus(1'b1, 22'h2AAAAA, 8'hFF, 1'b1);
        tick();
        applyStimulus(1'b1, 22'h2AAAAA, 8'hFB, 1'b1);
        tick();
        checkRsp("t2a", 1'b1, 3'd2, 8'h44, 1'b1);
        applyStimulus(1'b0, 22'h000000, 8'h00, 1'b1);
        tick();
        checkRsp("t2b", 1'b1, 3'd6, 8'h40, 1'b0);
        tick();
        checkOutput("t2_hit_count", 32'(hit_count), 32'd3);

        // Masked matching way, then all ways invalid
        tags = base_tags;
        tags[3*TAG_SIZE +: TAG_SIZE] = 22'h333333;
        applyStimulus(1'b1, 22'h333333, 8'hF7, 1'b1);
        tick();
        applyStimulus(1'b1, 22'h100000, 8'h00, 1'b1);
        tick();
        checkRsp("t3a", 1'b0, 3'd0, 8'h00, 1'b0);
        applyStimulus(1'b0, 22'h000000, 8'h00, 1'b1);
        tick();
        checkRsp("t3b", 1'b0, 3'd0, 8'h00, 1'b0);
        tick();
        checkOutput("t3_miss_count", 32'(miss_count), 32'd2);
        checkOutput("t3_hit_count", 32'(hit_count), 32'd3);

        // Four back-to-back requests with a three-cycle response stall
        tags = base_tags;
        applyStimulus(1'b1, 22'h100000, 8'hFF, 1'b1);
        tick();
        applyStimulus(1'b1, 22'h3FFFFF, 8'hFF, 1'b1);
        #1;
        checkOutput("t4_ready_b", 32'(bus.req_ready), 32'd1);
        tick();
        applyStimulus(1'b1, 22'h100007, 8'hFF, 1'b0);
        #1;
        checkOutput("t4_ready_full", 32'(bus.req_ready), 32'd0);
        checkRsp("t4a", 1'b1, 3'd0, 8'h01, 1'b0);
        tick();
        checkRsp("t4a_stall1", 1'b1, 3'd0, 8'h01, 1'b0);
        checkOutput("t4_ready_stall1", 32'(bus.req_ready), 32'd0);
        tick();
        checkRsp("t4a_stall2", 1'b1, 3'd0, 8'h01, 1'b0);
        checkOutput("t4_ready_stall2", 32'(bus.req_ready), 32'd0);
        tick();
        applyStimulus(1'b1, 22'h100007, 8'hFF, 1'b1);
        #1;
        checkRsp("t4a_stall3", 1'b1, 3'd0, 8'h01, 1'b0);
        checkOutput("t4_ready_release", 32'(bus.req_ready), 32'd1);
        tick();
        checkRsp("t4b", 1'b0, 3'd0, 8'h00, 1'b0);
        applyStimulus(1'b1, 22'h100001, 8'hFF, 1'b1);
        tick();
        checkRsp("t4c", 1'b1, 3'd7, 8'h80, 1'b0);
        applyStimulus(1'b0, 22'h000000, 8'h00, 1'b1);
        tick();
        checkRsp("t4d", 1'b1, 3'd1, 8'h02, 1'b0);
        tick();
        checkOutput("t4_drain", 32'(bus.rsp_valid), 32'd0);
        checkOutput("t4_hit_count", 32'(hit_count), 32'd6);
        checkOutput("t4_miss_count", 32'(miss_count), 32'd3);

        // Clear, saturate the hit counter, then clear against a live handshake
        clr_counts = 1'b1;
        tick();
        clr_counts = 1'b0;
        checkOutput("t5_clr_hit", 32'(hit_count), 32'd0);
        checkOutput("t5_clr_miss", 32'(miss_count), 32'd0);
        for (int k = 0; k < 17; k++) begin
            applyStimulus(1'b1, 22'h100000, 8'hFF, 1'b1);
            tick();
        end
        applyStimulus(1'b0, 22'h000000, 8'h00, 1'b1);
        tick();
        checkOutput("t5_sat_hit", 32'(hit_count), 32'd15);
        checkOutput("t5_sat_miss", 32'(miss_count), 32'd0);
        checkOutput("t5_last_valid", 32'(bus.rsp_valid), 32'd1);
        clr_counts = 1'b1;
        tick();
        clr_counts = 1'b0;
        checkOutput("t5_clr_wins", 32'(hit_count), 32'd0);
        checkOutput("t5_drain", 32'(bus.rsp_valid), 32'd0);

        // Reset with two lookups in flight
        applyStimulus(1'b1, 22'h100000, 8'hFF, 1'b1);
        tick();
        tick();
        tick();
        checkOutput("t6_pre_hit", 32'(hit_count), 32'd1);
        checkOutput("t6_pre_valid", 32'(bus.rsp_valid), 32'd1);
        rst = 1'b1;
        applyStimulus(1'b0, 22'h000000, 8'h00, 1'b1);
        #1;
        checkOutput("t6_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("t6_rsp_hit", 32'(bus.rsp_hit), 32'd0);
        checkOutput("t6_hit_vec", 32'(bus.rsp_hit_vec), 32'd0);
        checkOutput("t6_hit_count", 32'(hit_count), 32'd0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("t6_no_stale", 32'(bus.rsp_valid), 32'd0);
        end
        checkOutput("t6_req_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("t6_hit_after", 32'(hit_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
